// File: rtl/dct_transpose_buf.sv
// Ping-pong NxN transpose buffer between the row and column passes of a 2D DCT.
// Optional sticky input-drop flag `err_drop` when TRANSPOSE_ERR_EN is defined.
module dct_transpose_buf #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned N      = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_col_start,
`ifdef TRANSPOSE_ERR_EN
  output logic                     err_drop,
`endif
  output logic                     out_blk_last
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned LOG_N = $clog2(N);
  localparam int unsigned IDX_W = 2 * LOG_N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  logic signed [DATA_W-1:0] mem_q [2][NN];

  logic                     wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic [1:0]               bank_full_q, bank_full_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     col_start_q, col_start_d;
  logic                     blk_last_q, blk_last_d;

  logic                     wr_hs;
  logic                     load;
  logic [IDX_W-1:0]         rd_addr;
  logic [1:0]               set_full;
  logic [1:0]               clr_full;

  assign in_ready = ~bank_full_q[wr_bank_q];

  // Next-state: write pointer, column-major read into the output register, bank flags.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    col_start_d = col_start_q;
    blk_last_d  = blk_last_q;
    set_full    = 2'b00;
    clr_full    = 2'b00;

    wr_hs   = in_valid & in_ready;
    load    = bank_full_q[rd_bank_q] & (~out_valid_q | out_ready);
    // rd_idx = {col, row}; the stored address is {row, col}.
    rd_addr = {rd_idx_q[LOG_N-1:0], rd_idx_q[IDX_W-1:LOG_N]};

    if (wr_hs) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
      if (wr_idx_q == LAST_IDX) begin
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end
    end

    if (load) begin
      out_data_d  = mem_q[rd_bank_q][rd_addr];
      col_start_d = (rd_idx_q[LOG_N-1:0] == LOG_N'(0));
      blk_last_d  = (rd_idx_q == LAST_IDX);
      out_valid_d = 1'b1;
      rd_idx_d    = rd_idx_q + IDX_W'(1);
      if (rd_idx_q == LAST_IDX) begin
        clr_full[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Set and clear never hit the same bank in one cycle.
    bank_full_d = (bank_full_q | set_full) & ~clr_full;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      bank_full_q <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      col_start_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      bank_full_q <= bank_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      col_start_q <= col_start_d;
      blk_last_q  <= blk_last_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_col_start = col_start_q;
  assign out_blk_last  = blk_last_q;

`ifdef TRANSPOSE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_drop = err_q;
`endif

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Bench for dct_transpose_buf: directed tables, corner sequences and a randomized scoreboard.
module tb_dct_transpose_buf;

  localparam int DATA_W = 12;
  localparam int N      = 8;
  localparam int NN     = N * N;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_col_start;
  logic                     out_blk_last;
`ifdef TRANSPOSE_ERR_EN
  logic                     err_drop;
`endif

  always #5 clk = ~clk;

  dct_transpose_buf #(.DATA_W(DATA_W), .N(N)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_col_start (out_col_start),
`ifdef TRANSPOSE_ERR_EN
    .err_drop      (err_drop),
`endif
    .out_blk_last  (out_blk_last)
  );

  typedef struct {
    logic signed [DATA_W-1:0] data;
    logic                     cs;
    logic                     last;
  } out_rec_t;

  typedef struct {
    logic signed [DATA_W-1:0] in_val;
    logic signed [DATA_W-1:0] exp_data;
    logic                     exp_cs;
    logic                     exp_last;
  } vec_t;

  typedef struct {
    int                       addr;
    logic signed [DATA_W-1:0] val;
    int                       out_idx;
  } ext_t;

  out_rec_t                 exp_q[$];
  out_rec_t                 got_q[$];
  int                       got_cyc[$];
  logic signed [DATA_W-1:0] blk_in[$];
  int                       blocks_done = 0;
  int                       consumed = 0;
  int                       stall_cnt = 0;
  int                       cyc = 0;
  int                       checks = 0;
  int                       failures = 0;
  logic                     hold_v = 1'b0;
  out_rec_t                 hold_r;
  out_rec_t                 mon_e;
  int                       pend_hi, pend_lo;

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: transposes each completed input block and checks every output handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
    end else begin
      pend_hi = blocks_done - consumed / NN;
      pend_lo = blocks_done - (consumed + 1) / NN;
      if (pend_hi < 2) chk("in_ready_open", in_ready, 1);
      if (pend_lo >= 2) chk("in_ready_full", in_ready, 0);
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_r.data);
        chk("hold_cs", out_col_start, hold_r.cs);
        chk("hold_last", out_blk_last, hold_r.last);
      end
      hold_v      = out_valid && !out_ready;
      hold_r.data = out_data;
      hold_r.cs   = out_col_start;
      hold_r.last = out_blk_last;
      if (in_valid && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        got_q.push_back('{out_data, out_col_start, out_blk_last});
        got_cyc.push_back(cyc);
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0d expected no output", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_data", out_data, mon_e.data);
          chk("sb_col_start", out_col_start, mon_e.cs);
          chk("sb_blk_last", out_blk_last, mon_e.last);
        end
      end
      if (in_valid && in_ready) begin
        blk_in.push_back(in_data);
        if (blk_in.size() == NN) begin
          for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++)
              exp_q.push_back('{blk_in[r*N+c], (r == 0), (c*N+r == NN-1)});
          blk_in.delete();
          blocks_done++;
        end
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
    blk_in.delete();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    blocks_done = 0;
    consumed    = 0;
    hold_v      = 1'b0;
  endtask

  // Offers one value and returns at posedge+1 after it is accepted.
  task automatic send(input logic signed [DATA_W-1:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", (exp_q.size() != 0 || out_valid) ? 1 : 0, 0);
    @(posedge clk); #1;
  endtask

  vec_t                     tv [NN];
  ext_t                     ext [4];
  logic signed [DATA_W-1:0] vals [NN];
  int                       max_gap, t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NN; k++) begin
      tv[k].in_val   = DATA_W'(k);
      tv[k].exp_data = DATA_W'((k % N) * N + k / N);
      tv[k].exp_cs   = (k % N == 0);
      tv[k].exp_last = (k == NN - 1);
    end
    ext[0] = '{0,  -12'sd2048, 0};
    ext[1] = '{9,   12'sd2047, 9};
    ext[2] = '{18, -12'sd1,    18};
    ext[3] = '{63,  12'sd0,    63};

    // Reset state
    do_reset(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_col_start", out_col_start, 0);
    chk("rst_blk_last", out_blk_last, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single block, table-driven, with first-output latency
    out_ready = 1'b1;
    for (int k = 0; k < NN; k++) send(tv[k].in_val);
    chk("lat_before", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_after", out_valid, 1);
    wait_drain();
    chk("single_count", got_q.size(), NN);
    if (got_q.size() == NN) begin
      for (int k = 0; k < NN; k++) begin
        chk("tbl_data", got_q[k].data, tv[k].exp_data);
        chk("tbl_cs", got_q[k].cs, tv[k].exp_cs);
        chk("tbl_last", got_q[k].last, tv[k].exp_last);
      end
    end

    // Two back-to-back blocks
    got_q.delete();
    got_cyc.delete();
    stall_cnt = 0;
    for (int k = 0; k < NN; k++) send(DATA_W'(k));
    for (int k = 0; k < NN; k++) send(DATA_W'(100 + k));
    wait_drain();
    chk("b2b_no_stall", stall_cnt, 0);
    chk("b2b_count", got_q.size(), 2 * NN);
    if (got_q.size() == 2 * NN) begin
      max_gap = 0;
      for (int i = 1; i < 2 * NN; i++)
        if (got_cyc[i] - got_cyc[i-1] > max_gap) max_gap = got_cyc[i] - got_cyc[i-1];
      chk("b2b_gap", max_gap, 1);
      chk("b2b_blk2_first", got_q[NN].data, 100);
      chk("b2b_blk2_second", got_q[NN+1].data, 108);
      chk("b2b_blk2_col0_end", got_q[NN+7].data, 156);
      chk("b2b_blk2_last", got_q[2*NN-1].data, 163);
      chk("b2b_blk2_cs", got_q[NN].cs, 1);
    end

    // Backpressure: both banks fill, output register holds
    do_reset(1);
    out_ready = 1'b0;
    for (int k = 0; k < NN; k++) send(DATA_W'(k));
    for (int k = 0; k < NN; k++) send(DATA_W'(200 + k));
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 0);
    chk("bp_cs", out_col_start, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_data", out_data, 0);
    chk("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("bp_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_consumed_at_reopen", got_q.size(), NN);
    wait_drain();
    chk("bp_total", got_q.size(), 2 * NN);

    // Sign extremes
    do_reset(1);
    out_ready = 1'b1;
    for (int k = 0; k < NN; k++) vals[k] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) vals[ext[i].addr] = ext[i].val;
    for (int k = 0; k < NN; k++) send(vals[k]);
    wait_drain();
    chk("ext_count", got_q.size(), NN);
    if (got_q.size() == NN) begin
      for (int i = 0; i < 4; i++) chk("ext_value", got_q[ext[i].out_idx].data, ext[i].val);
    end

    // Reset in the middle of a block
    do_reset(1);
    for (int k = 0; k < 30; k++) send(DATA_W'($urandom));
    do_reset(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int k = 0; k < NN; k++) send(DATA_W'(500 + k));
    wait_drain();
    chk("mid_rst_count", got_q.size(), NN);
    if (got_q.size() == NN) begin
      for (int k = 0; k < NN; k++) chk("mid_rst_data", got_q[k].data, 500 + (k % N) * N + k / N);
    end

    // Randomized traffic against the scoreboard
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("rand_total", got_q.size(), blocks_done * NN);

`ifdef TRANSPOSE_ERR_EN
    // Sticky drop flag
    do_reset(1);
    chk("err_rst", err_drop, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 2 * NN; k++) send(DATA_W'(k));
    chk("err_before_drop", err_drop, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("err_set", err_drop, 1);
    out_ready = 1'b1;
    wait_drain();
    chk("err_sticky", err_drop, 1);
    do_reset(1);
    chk("err_cleared", err_drop, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
